bitbakery_serial_rx: RTL and testbench
======================================

// Module: bitbakery_serial_rx
// PURPOSE
//  Receiving end of the BitBakery 8E1 game link. Deserialises the 133-byte packet:
//  0xFF start, D0, D1, D2, 64 obstacle bytes, 64 objective bytes, 0xFE end.
//  Assembles the packet in a shadow buffer and commits it atomically to its outputs
//  only after a clean end byte. Sits on the board that consumes game state from the transmitter.
// PARAMETERS
//  CLKS_PER_BIT  434      clocks per serial bit (50 MHz / 115200 baud)
//  TIMEOUT_CLKS  100000   max idle clocks between bytes inside a packet (RX_TIMEOUT_EN only)
// PORTS
//  clock           in   1    system clock, all logic on rising edge
//  reset           in   1    asynchronous, active-low; clears all state and outputs
//  entrada_serial  in   1    8E1 line, idle high
//  D0,D1,D2        out  8    committed data bytes 1..3 of packet
//  map_obstacles   out  512  committed obstacle bytes; byte k -> [8k+7:8k], k=0..63
//  map_objectives  out  512  committed objective bytes; byte k -> [8k+7:8k]
//  pronto          out  1    1-cycle pulse: new packet committed
//  erro_paridade   out  1    1-cycle pulse: byte received with odd total parity
//  erro_quadro     out  1    1-cycle pulse: stop bit sampled low
//  erro_pacote     out  1    1-cycle pulse: bad end byte or inter-byte timeout
//  db_estado       out  2    packet FSM state, debug
// BEHAVIOUR
//  - entrada_serial passes a 2-FF synchroniser (reset value 1).
//  - Bit receiver: IDLE -> START on falling edge.
//    START waits CLKS_PER_BIT/2 and rechecks low; if high -> IDLE (glitch, no error).
//    DATA samples 8 bits, LSB first, one every CLKS_PER_BIT. PARITY samples 1 bit.
//    STOP samples 1 bit.
//    Next cycle: byte_ok pulse if even parity and stop=1; otherwise error pulse, byte dropped.
//    Returns to IDLE right after the stop sample, so back-to-back frames are not lost.
//  - Packet FSM (db_estado):
//    HUNT=0: ignore bytes until 0xFF; on 0xFF set idx=1 -> BODY.
//    BODY=1: each byte_ok stores to shadow slot idx, then idx++.
//      idx 1..3 -> D0..D2; 4..67 -> obstacles k=idx-4; 68..131 -> objectives k=idx-68.
//      At idx=132: 0xFE -> COMMIT; else erro_pacote pulse -> HUNT.
//    COMMIT=2: copy shadow to outputs, pronto=1 for this cycle, idx=0 -> HUNT.
//  - Latency: outputs and pronto change 2 clocks after the end byte's stop-bit sample.
//  - Parity or framing error in BODY: error pulse, discard partial packet -> HUNT.
//    Outputs keep the previous committed packet.
//  - 0xFF inside BODY is data, not a resync.
//  - 0xFE at any idx<132 is data.
//  - Outputs never show a partially received packet.
//  - Reset, including mid-packet:
//    all outputs 0; FSMs in IDLE/HUNT; idx=0; shadow cleared; synchroniser at 1.
//  - Counters are sized by $clog2; idx is 8 bits, max 132, never wraps.
// CONFIGURATION
//  RX_TIMEOUT_EN defined:
//    In BODY, a gap counter resets on each byte_ok.
//    Reaching TIMEOUT_CLKS -> erro_pacote pulse, discard -> HUNT.
//  RX_TIMEOUT_EN undefined: no gap counter; BODY waits indefinitely.
// STRUCTURE
//  - Shared include bitbakery_serial_defs.vh:
//    START_BYTE=8'hFF, END_BYTE=8'hFE, PKT_LEN=133, state encodings.
//    The transmitter uses the same include.
//  - Sub-module rx_serial_8E1: synchroniser, bit FSM, parity/stop check.
//    Outputs dados[7:0], byte_ok, erro_paridade, erro_quadro.
//  - Top module: packet FSM, idx counter, shadow buffer, commit, timeout.
// TESTING
//  1. Valid packet D0=12h, D1=34h, D2=56h, obstacle k=k, objective k=~k:
//     one pronto pulse; D0..D2 correct; map_obstacles[15:8]=01h;
//     map_objectives[7:0]=FFh.
//  2. Flip the parity bit of byte idx 10:
//     erro_paridade pulse, no pronto, outputs unchanged.
//     The next valid packet is accepted.
//  3. End byte FDh instead of FEh:
//     erro_pacote pulse at idx 132, no pronto, outputs hold the previous packet.
//  4. Bytes 00h, 55h, FEh, then a valid packet:
//     the leading bytes are ignored; exactly one pronto.
//  5. Valid packet with D1=FFh and obstacle 0=FEh: accepted, values intact.
//  6. reset low during byte 70:
//     all outputs 0 immediately; a following valid packet commits normally.
//  7. (RX_TIMEOUT_EN) Stop after 20 bytes and idle > TIMEOUT_CLKS:
//     erro_pacote pulse, db_estado=0.
//     Without the macro: db_estado stays 1.

Source files
------------

// File: rtl/bitbakery_serial_rx_pkg.sv
// Shared constants and state encodings for the BitBakery game link (receiver and transmitter).
package bitbakery_serial_rx_pkg;

    localparam logic [7:0] START_BYTE = 8'hFF;
    localparam logic [7:0] END_BYTE   = 8'hFE;
    localparam int         PKT_LEN    = 133;
    localparam logic [7:0] END_IDX    = 8'(PKT_LEN - 1);
    localparam int         N_MAP      = 64;

    typedef enum logic [1:0] {
        PKT_HUNT   = 2'd0,
        PKT_BODY   = 2'd1,
        PKT_COMMIT = 2'd2
    } pkt_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    function automatic logic even_parity_ok(input logic [7:0] d, input logic p);
        return ~(^{d, p});
    endfunction

endpackage

// File: rtl/rx_serial_8E1.sv
// 8E1 byte receiver: input synchroniser, bit-timing FSM, parity and stop-bit check.
//  state     | meaning
//  RX_IDLE   | line idle, waiting for falling edge
//  RX_START  | half-bit wait, recheck start bit low
//  RX_DATA   | sampling 8 data bits, LSB first
//  RX_PARITY | sampling parity bit
//  RX_STOP   | sampling stop bit, then back to idle
module rx_serial_8E1
    import bitbakery_serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       entrada_serial,
    output logic [7:0] dados,
    output logic       byte_ok,
    output logic       erro_paridade,
    output logic       erro_quadro
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    rx_state_e     state_q, state_d;
    logic          sync1_q, sync2_q, prev_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_q;
    logic [7:0]    shift_q, dados_q;
    logic          par_q, ok_q, perr_q, ferr_q;
    logic          tc, fall;
    logic          load_half, load_full, smp_data, smp_par, smp_stop;

    assign tc   = (cnt_q == '0);
    assign fall = prev_q & ~sync2_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:   if (fall) state_d = RX_START;
            RX_START:  if (tc) state_d = sync2_q ? RX_IDLE : RX_DATA;
            RX_DATA:   if (tc && bit_q == 3'd7) state_d = RX_PARITY;
            RX_PARITY: if (tc) state_d = RX_STOP;
            RX_STOP:   if (tc) state_d = RX_IDLE;
            default:   state_d = RX_IDLE;
        endcase
    end

    always_comb begin
        load_half = (state_q == RX_IDLE) && fall;
        load_full = tc && (((state_q == RX_START) && !sync2_q) ||
                           (state_q == RX_DATA) || (state_q == RX_PARITY));
        smp_data  = tc && (state_q == RX_DATA);
        smp_par   = tc && (state_q == RX_PARITY);
        smp_stop  = tc && (state_q == RX_STOP);
    end

    // Verdict is registered on the stop sample so it appears the following cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            dados_q <= '0;
            ok_q    <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync1_q <= entrada_serial;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            if (load_half)      cnt_q <= CNT_HALF;
            else if (load_full) cnt_q <= CNT_FULL;
            else if (!tc)       cnt_q <= cnt_q - 1'b1;
            if (load_half) bit_q <= '0;
            if (smp_data) begin
                shift_q <= {sync2_q, shift_q[7:1]};
                bit_q   <= bit_q + 1'b1;
            end
            if (smp_par)  par_q   <= sync2_q;
            if (smp_stop) dados_q <= shift_q;
            ok_q   <= smp_stop && sync2_q && even_parity_ok(shift_q, par_q);
            perr_q <= smp_stop && !even_parity_ok(shift_q, par_q);
            ferr_q <= smp_stop && !sync2_q;
        end
    end

    assign dados         = dados_q;
    assign byte_ok       = ok_q;
    assign erro_paridade = perr_q;
    assign erro_quadro   = ferr_q;

endmodule

// File: rtl/bitbakery_serial_rx.sv
// BitBakery packet receiver: assembles 133-byte packets in a shadow buffer and commits atomically.
// Optional inter-byte timeout in BODY is enabled by defining RX_TIMEOUT_EN.
//  state      | meaning
//  PKT_HUNT   | discard bytes until start byte
//  PKT_BODY   | store bytes to shadow slot idx, check end byte at idx 132
//  PKT_COMMIT | copy shadow to outputs, pulse pronto
module bitbakery_serial_rx
    import bitbakery_serial_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 100000
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         entrada_serial,
    output logic [7:0]   D0,
    output logic [7:0]   D1,
    output logic [7:0]   D2,
    output logic [511:0] map_obstacles,
    output logic [511:0] map_objectives,
    output logic         pronto,
    output logic         erro_paridade,
    output logic         erro_quadro,
    output logic         erro_pacote,
    output logic [1:0]   db_estado
);

    logic [7:0]   dados;
    logic         byte_ok, rx_perr, rx_ferr;
    pkt_state_e   state_q, state_d;
    logic [7:0]   idx_q;
    logic [7:0]   shadow_q [0:PKT_LEN-3];
    logic [7:0]   d0_q, d1_q, d2_q;
    logic [511:0] obs_q, obj_q, obs_shadow, obj_shadow;
    logic         pronto_q, pkt_err_q;
    logic         hunt_start, store, end_bad, commit, timeout;

    rx_serial_8E1 #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .dados          (dados),
        .byte_ok        (byte_ok),
        .erro_paridade  (rx_perr),
        .erro_quadro    (rx_ferr)
    );

`ifdef RX_TIMEOUT_EN
    localparam int            GW       = $clog2(TIMEOUT_CLKS);
    localparam logic [GW-1:0] GAP_LOAD = GW'(TIMEOUT_CLKS - 1);
    logic [GW-1:0] gap_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)                              gap_q <= '0;
        else if (state_q != PKT_BODY || byte_ok) gap_q <= GAP_LOAD;
        else if (gap_q != '0)                    gap_q <= gap_q - 1'b1;
    end

    assign timeout = (state_q == PKT_BODY) && !byte_ok && (gap_q == '0);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= PKT_HUNT;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PKT_HUNT:
                if (byte_ok && dados == START_BYTE) state_d = PKT_BODY;
            PKT_BODY:
                if (rx_perr || rx_ferr || timeout)
                    state_d = PKT_HUNT;
                else if (byte_ok && idx_q == END_IDX)
                    state_d = (dados == END_BYTE) ? PKT_COMMIT : PKT_HUNT;
            PKT_COMMIT:
                state_d = PKT_HUNT;
            default:
                state_d = PKT_HUNT;
        endcase
    end

    always_comb begin
        hunt_start = (state_q == PKT_HUNT) && byte_ok && (dados == START_BYTE);
        store      = (state_q == PKT_BODY) && byte_ok && (idx_q != END_IDX);
        end_bad    = (state_q == PKT_BODY) && byte_ok && (idx_q == END_IDX) && (dados != END_BYTE);
        commit     = (state_q == PKT_COMMIT);
        obs_shadow = '0;
        obj_shadow = '0;
        for (int k = 0; k < N_MAP; k++) begin
            obs_shadow[8*k +: 8] = shadow_q[3 + k];
            obj_shadow[8*k +: 8] = shadow_q[3 + N_MAP + k];
        end
    end

    // Shadow slot is idx-1; the end byte at idx 132 is checked but never stored.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idx_q     <= '0;
            d0_q      <= '0;
            d1_q      <= '0;
            d2_q      <= '0;
            obs_q     <= '0;
            obj_q     <= '0;
            pronto_q  <= 1'b0;
            pkt_err_q <= 1'b0;
            for (int i = 0; i < PKT_LEN - 2; i++) shadow_q[i] <= '0;
        end else begin
            if (hunt_start)              idx_q <= 8'd1;
            else if (store)              idx_q <= idx_q + 8'd1;
            else if (state_d != PKT_BODY) idx_q <= '0;
            if (store) shadow_q[idx_q - 8'd1] <= dados;
            pronto_q  <= commit;
            pkt_err_q <= end_bad || timeout;
            if (commit) begin
                d0_q  <= shadow_q[0];
                d1_q  <= shadow_q[1];
                d2_q  <= shadow_q[2];
                obs_q <= obs_shadow;
                obj_q <= obj_shadow;
            end
        end
    end

    assign D0             = d0_q;
    assign D1             = d1_q;
    assign D2             = d2_q;
    assign map_obstacles  = obs_q;
    assign map_objectives = obj_q;
    assign pronto         = pronto_q;
    assign erro_paridade  = rx_perr;
    assign erro_quadro    = rx_ferr;
    assign erro_pacote    = pkt_err_q;
    assign db_estado      = state_q;

endmodule

// File: tb/tb_bitbakery_serial_rx.sv
// Directed + randomized bench for bitbakery_serial_rx; expectations come from a packet-level model.
module tb_bitbakery_serial_rx;

    localparam int CPB = 6;
    localparam int TO  = 3000;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         entrada_serial = 1'b1;
    logic [7:0]   D0, D1, D2;
    logic [511:0] map_obstacles, map_objectives;
    logic         pronto, erro_paridade, erro_quadro, erro_pacote;
    logic [1:0]   db_estado;

    bitbakery_serial_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clock          (clock),
        .reset          (reset),
        .entrada_serial (entrada_serial),
        .D0             (D0),
        .D1             (D1),
        .D2             (D2),
        .map_obstacles  (map_obstacles),
        .map_objectives (map_objectives),
        .pronto         (pronto),
        .erro_paridade  (erro_paridade),
        .erro_quadro    (erro_quadro),
        .erro_pacote    (erro_pacote),
        .db_estado      (db_estado)
    );

    always #5 clock = ~clock;

    int n_assert = 0;
    int n_fail   = 0;
    int c_pronto = 0, c_perr = 0, c_ferr = 0, c_pkt = 0;
    int p0, e0, f0, k0;
    logic [7:0]   snap_d0;
    logic [511:0] snap_obs;

    // committed packet body as the model sees it: slot i holds packet byte i+1
    logic [7:0] exp_b [0:130];
    logic [7:0] pkt   [0:132];

    always @(negedge clock) begin
        if (pronto) begin
            c_pronto++;
            snap_d0  = D0;
            snap_obs = map_obstacles;
        end
        if (erro_paridade) c_perr++;
        if (erro_quadro)   c_ferr++;
        if (erro_pacote)   c_pkt++;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] pack_map(input int base);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < 64; k++) r[8*k +: 8] = exp_b[base + k];
        return r;
    endfunction

    task automatic send_bit(input logic v);
        entrada_serial = v;
        repeat (CPB) @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((^b) ^ bad_par);
        send_bit(~bad_stop);
        entrada_serial = 1'b1;
    endtask

    task automatic idle(input int n);
        entrada_serial = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic make_random();
        pkt[0] = 8'hFF;
        for (int i = 1; i < 132; i++) pkt[i] = 8'($urandom);
        pkt[132] = 8'hFE;
    endtask

    task automatic send_pkt(input int n);
        for (int i = 0; i < n; i++) send_byte(pkt[i], 1'b0, 1'b0);
    endtask

    task automatic accept_pkt();
        for (int i = 0; i < 131; i++) exp_b[i] = pkt[i + 1];
    endtask

    task automatic snap_counts();
        p0 = c_pronto; e0 = c_perr; f0 = c_ferr; k0 = c_pkt;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_d0"},  512'(D0), 512'(exp_b[0]));
        chk({tag, "_d1"},  512'(D1), 512'(exp_b[1]));
        chk({tag, "_d2"},  512'(D2), 512'(exp_b[2]));
        chk({tag, "_obs"}, map_obstacles,  pack_map(3));
        chk({tag, "_obj"}, map_objectives, pack_map(67));
    endtask

    initial begin
        for (int i = 0; i < 131; i++) exp_b[i] = 8'h00;

        // reset state
        idle(5);
        chk("rst_db", 512'(db_estado), 512'(0));
        chk("rst_pronto", 512'(pronto), 512'(0));
        check_outputs("rst");
        reset = 1'b1;
        idle(4 * CPB);

        // 1: directed valid packet
        pkt[0] = 8'hFF; pkt[1] = 8'h12; pkt[2] = 8'h34; pkt[3] = 8'h56;
        for (int k = 0; k < 64; k++) begin
            pkt[4 + k]  = 8'(k);
            pkt[68 + k] = 8'(~k);
        end
        pkt[132] = 8'hFE;
        snap_counts();
        send_pkt(133);
        idle(20);
        accept_pkt();
        chk("t1_pronto_cnt", 512'(c_pronto - p0), 512'(1));
        check_outputs("t1");
        chk("t1_obs1", 512'(map_obstacles[15:8]), 512'(8'h01));
        chk("t1_obj0", 512'(map_objectives[7:0]), 512'(8'hFF));
        chk("t1_snap_d0", 512'(snap_d0), 512'(8'h12));
        chk("t1_snap_obs", snap_obs, pack_map(3));

        // 2: parity error on byte 10, then a good packet
        make_random();
        snap_counts();
        for (int i = 0; i < 10; i++) send_byte(pkt[i], 1'b0, 1'b0);
        send_byte(pkt[10], 1'b1, 1'b0);
        idle(20);
        chk("t2_perr_cnt", 512'(c_perr - e0), 512'(1));
        chk("t2_pronto_cnt", 512'(c_pronto - p0), 512'(0));
        chk("t2_db", 512'(db_estado), 512'(0));
        check_outputs("t2_hold");
        make_random();
        snap_counts();
        send_pkt(133);
        idle(20);
        accept_pkt();
        chk("t2b_pronto_cnt", 512'(c_pronto - p0), 512'(1));
        check_outputs("t2b");

        // 3: bad end byte
        make_random();
        pkt[132] = 8'hFD;
        snap_counts();
        send_pkt(133);
        idle(20);
        chk("t3_pkterr_cnt", 512'(c_pkt - k0), 512'(1));
        chk("t3_pronto_cnt", 512'(c_pronto - p0), 512'(0));
        chk("t3_db", 512'(db_estado), 512'(0));
        check_outputs("t3_hold");

        // 4: junk before the start byte
        snap_counts();
        send_byte(8'h00, 1'b0, 1'b0);
        send_byte(8'h55, 1'b0, 1'b0);
        send_byte(8'hFE, 1'b0, 1'b0);
        make_random();
        send_pkt(133);
        idle(20);
        accept_pkt();
        chk("t4_pronto_cnt", 512'(c_pronto - p0), 512'(1));
        chk("t4_err_cnt", 512'((c_perr - e0) + (c_ferr - f0) + (c_pkt - k0)), 512'(0));
        check_outputs("t4");

        // 5: start/end values used as data
        make_random();
        pkt[2] = 8'hFF;
        pkt[4] = 8'hFE;
        snap_counts();
        send_pkt(133);
        idle(20);
        accept_pkt();
        chk("t5_pronto_cnt", 512'(c_pronto - p0), 512'(1));
        chk("t5_d1_ff", 512'(D1), 512'(8'hFF));
        chk("t5_obs0_fe", 512'(map_obstacles[7:0]), 512'(8'hFE));
        check_outputs("t5");

        // 6: reset in the middle of byte 70
        make_random();
        send_pkt(70);
        chk("t6_db_body", 512'(db_estado), 512'(1));
        send_bit(1'b0);
        send_bit(pkt[70][0]);
        send_bit(pkt[70][1]);
        reset = 1'b0;
        #1;
        for (int i = 0; i < 131; i++) exp_b[i] = 8'h00;
        chk("t6_rst_db", 512'(db_estado), 512'(0));
        check_outputs("t6_rst");
        idle(5);
        reset = 1'b1;
        idle(4 * CPB);
        make_random();
        snap_counts();
        send_pkt(133);
        idle(20);
        accept_pkt();
        chk("t6_pronto_cnt", 512'(c_pronto - p0), 512'(1));
        check_outputs("t6");

        // framing error and a short glitch while hunting
        snap_counts();
        send_byte(8'h3C, 1'b0, 1'b1);
        idle(20);
        chk("fe_ferr_cnt", 512'(c_ferr - f0), 512'(1));
        chk("fe_db", 512'(db_estado), 512'(0));
        snap_counts();
        entrada_serial = 1'b0;
        @(negedge clock);
        idle(30);
        chk("glitch_err_cnt", 512'((c_perr - e0) + (c_ferr - f0) + (c_pkt - k0)), 512'(0));
        chk("glitch_db", 512'(db_estado), 512'(0));
        check_outputs("glitch_hold");

        // 7: stall after 20 bytes
        make_random();
        snap_counts();
        send_pkt(20);
        idle(TO + 200);
`ifdef RX_TIMEOUT_EN
        chk("t7_pkterr_cnt", 512'(c_pkt - k0), 512'(1));
        chk("t7_db", 512'(db_estado), 512'(0));
`else
        chk("t7_pkterr_cnt", 512'(c_pkt - k0), 512'(0));
        chk("t7_db", 512'(db_estado), 512'(1));
`endif
        chk("t7_pronto_cnt", 512'(c_pronto - p0), 512'(0));
        check_outputs("t7_hold");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
